// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage core: load-use, taken-branch, data-memory wait, debug drain-to-halt.
// Optional performance counters are compiled in when PIPE_CTRL_PERF_EN is defined.
module pipeline_stall_ctrl #(
  parameter int DRAIN_CYCLES = 4,
  parameter int MEM_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic        halt_req,
  input  logic        resume,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        ex_mem_en,
  output logic        mem_wb_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic        mem_wb_flush,
  output logic        halted,
  output logic        err_mem_timeout
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flush_events
`endif
);

  localparam int WCW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam int DCW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam logic [WCW-1:0] WMAX = WCW'(MEM_TIMEOUT);
  localparam logic [DCW-1:0] DMAX = DCW'(DRAIN_CYCLES);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_DRAIN    = 2'd2,
    S_HALTED   = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic           ret_drain_q, ret_drain_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic [DCW-1:0] dcnt_q, dcnt_d;
  logic           err_q, err_d;

  logic mstall;
  logic lu;

  function automatic logic [WCW-1:0] wait_inc(input logic [WCW-1:0] v);
    return (v == WMAX) ? v : v + WCW'(1);
  endfunction

  function automatic logic [DCW-1:0] drain_inc(input logic [DCW-1:0] v);
    return (v == DMAX) ? v : v + DCW'(1);
  endfunction

  assign mstall = mem_req & ~mem_ready;
  assign lu     = ex_mem_read & (ex_rd != 5'd0) &
                  ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));

  always_comb begin
    state_d      = state_q;
    ret_drain_d  = ret_drain_q;
    wcnt_d       = wcnt_q;
    dcnt_d       = dcnt_q;
    err_d        = err_q;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    halted       = 1'b0;

    case (state_q)
      S_RUN, S_DRAIN: begin
        if (mstall) begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_en     = 1'b0;
          ex_mem_en    = 1'b0;
          mem_wb_flush = 1'b1;
          ret_drain_d  = (state_q == S_DRAIN);
          state_d      = S_MEM_WAIT;
        end else begin
          if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (lu) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
          end
          if (state_q == S_RUN) begin
            if (halt_req) state_d = S_DRAIN;
          end else begin
            // Fetch is shut off while draining, but a taken branch still loads its target.
            if (!ex_branch_taken) begin
              pc_en       = 1'b0;
              if_id_flush = 1'b1;
            end
            dcnt_d = drain_inc(dcnt_q);
            if (dcnt_d == DMAX) state_d = S_HALTED;
          end
        end
      end

      S_MEM_WAIT: begin
        if (!mem_ready) begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_en     = 1'b0;
          ex_mem_en    = 1'b0;
          mem_wb_flush = 1'b1;
          wcnt_d       = wait_inc(wcnt_q);
          if (wcnt_d == WMAX) err_d = 1'b1;
        end else begin
          // The release cycle advances the pipe, so it counts toward the drain.
          pc_en       = ~ret_drain_q;
          wcnt_d      = '0;
          ret_drain_d = 1'b0;
          if (ret_drain_q) begin
            dcnt_d  = drain_inc(dcnt_q);
            state_d = (dcnt_d == DMAX) ? S_HALTED : S_DRAIN;
          end else begin
            state_d = S_RUN;
          end
        end
      end

      S_HALTED: begin
        pc_en     = 1'b0;
        if_id_en  = 1'b0;
        id_ex_en  = 1'b0;
        ex_mem_en = 1'b0;
        mem_wb_en = 1'b0;
        halted    = 1'b1;
        if (resume) begin
          state_d = S_RUN;
          dcnt_d  = '0;
        end
      end

      default: state_d = S_RUN;
    endcase

    if (reset) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      mem_wb_flush = 1'b0;
      halted       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_RUN;
      ret_drain_q <= 1'b0;
      wcnt_q      <= '0;
      dcnt_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_drain_q <= ret_drain_d;
      wcnt_q      <= wcnt_d;
      dcnt_q      <= dcnt_d;
      err_q       <= err_d;
    end
  end

  assign err_mem_timeout = err_q & ~reset;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] pstall_q;
  logic [31:0] pflush_q;
  logic        br_flush;

  assign br_flush = ~reset & ((state_q == S_RUN) | (state_q == S_DRAIN)) & ~mstall & ex_branch_taken;

  always_ff @(posedge clk) begin
    if (reset) begin
      pstall_q <= '0;
      pflush_q <= '0;
    end else begin
      if (!pc_en && (state_q != S_HALTED)) pstall_q <= pstall_q + 32'd1;
      if (br_flush) pflush_q <= pflush_q + 32'd1;
    end
  end

  assign perf_stall_cycles = reset ? 32'd0 : pstall_q;
  assign perf_flush_events = reset ? 32'd0 : pflush_q;
`endif

endmodule
